// File: rtl/retrosoc_uart_rx.sv
// UART receiver: 8N1 LSB-first frames into a one-entry valid/ready holding register, with sticky error flags.
// Define RETROSOC_UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module retrosoc_uart_rx #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned DIV_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o,
  input  logic       clr_err_i,
  output logic       busy_o
);

  localparam logic [DIV_W-1:0] CNT_RELOAD = DIV_W'(BAUD_DIV - 1);
  localparam logic [DIV_W-1:0] CNT_HALF   = DIV_W'(BAUD_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] CNT_ONE    = DIV_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;
`ifdef RETROSOC_UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd3;
`endif

  logic [1:0]       sync_q;
  logic             rx_s;
  logic [2:0]       state, state_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [2:0]       bitcnt, bitcnt_d;
  logic [7:0]       sh, sh_d;
  logic             tick_c;
  logic             commit_c;
  logic             frame_set_c;
  logic             accept_c;
`ifdef RETROSOC_UART_RX_PARITY_EN
  logic             par_bad, par_bad_d;
  logic             parity_set_c;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rx_s = sync_q[1];

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      sh     <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      bitcnt <= bitcnt_d;
      sh     <= sh_d;
    end
  end

  // Next-state, bit timing and shift register
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bitcnt_d    = bitcnt;
    sh_d        = sh;
    commit_c    = 1'b0;
    frame_set_c = 1'b0;
    tick_c      = (cnt == '0);
`ifdef RETROSOC_UART_RX_PARITY_EN
    par_bad_d    = par_bad;
    parity_set_c = 1'b0;
`endif

    if (state != S_IDLE) begin
      cnt_d = tick_c ? CNT_RELOAD : cnt - CNT_ONE;
    end

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_d   = CNT_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (!rx_s) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          sh_d     = {rx_s, sh[7:1]};
          bitcnt_d = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
`ifdef RETROSOC_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef RETROSOC_UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_c) begin
          par_bad_d    = (^sh) ^ rx_s;
          parity_set_c = (^sh) ^ rx_s;
          state_d      = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick_c) begin
          if (rx_s) begin
`ifdef RETROSOC_UART_RX_PARITY_EN
            commit_c = !par_bad;
`else
            commit_c = 1'b1;
`endif
            state_d  = S_IDLE;
          end else begin
            frame_set_c = 1'b1;
            state_d     = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        // Hold off until the break ends so it is not taken as a new start bit
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign accept_c = !valid_o || ready_i;

  // Holding register, handshake and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o  <= 8'h00;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      busy_o <= (state_d != S_IDLE);
      if (commit_c && accept_c) begin
        data_o  <= sh;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  // Sticky flags; a set event beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (frame_set_c) begin
        frame_err_o <= 1'b1;
      end else if (clr_err_i) begin
        frame_err_o <= 1'b0;
      end
      if (commit_c && !accept_c) begin
        overrun_o <= 1'b1;
      end else if (clr_err_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

`ifdef RETROSOC_UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      par_bad <= par_bad_d;
      if (parity_set_c) begin
        parity_err_o <= 1'b1;
      end else if (clr_err_i) begin
        parity_err_o <= 1'b0;
      end
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_retrosoc_uart_rx.sv
// Directed bench for retrosoc_uart_rx at BAUD_DIV=8; expected values are hand-derived frame timings.
module tb_retrosoc_uart_rx;

  localparam int unsigned BD = 8;
`ifdef RETROSOC_UART_RX_PARITY_EN
  localparam int unsigned STOP_K = 10;
`else
  localparam int unsigned STOP_K = 9;
`endif
  // Start driven right after edge E: rx_s low after E+2, t0=E+3, stop sample at t0+BD/2+STOP_K*BD
  localparam int unsigned RISE_OFS = 3 + BD / 2 + STOP_K * BD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;
  logic       clr_err_i;
  logic       busy_o;

  int unsigned cyc = 0;
  int unsigned valid_cycles = 0;
  int unsigned busy_cycles = 0;
  int unsigned rise_cyc = 0;
  logic        valid_q = 1'b0;
  int unsigned passed = 0;
  int unsigned fails = 0;
  int unsigned e0;

  retrosoc_uart_rx #(.BAUD_DIV(BD), .DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o),
    .clr_err_i    (clr_err_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: valid/busy cycle counts and the cycle valid_o rose
  always @(negedge clk) begin
    if (valid_o) begin
      valid_cycles <= valid_cycles + 1;
      if (!valid_q) rise_cyc <= cyc;
    end
    if (busy_o) busy_cycles <= busy_cycles + 1;
    valid_q <= valid_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    @(posedge clk);
    #1;
    valid_cycles = 0;
    busy_cycles  = 0;
    rise_cyc     = 0;
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int unsigned stop_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RETROSOC_UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    rx_i = stop_b;
    repeat (BD * stop_bits) @(negedge clk);
    rx_i = 1'b1;
  endtask

`ifdef RETROSOC_UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    rx_i      = 1'b1;
    ready_i   = 1'b1;
    clr_err_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data_o), 32'h00);
    check("reset_valid", 32'(valid_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_flags", 32'({frame_err_o, overrun_o, parity_err_o}), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte with consumer ready
    clr_mon();
    e0 = cyc;
    send_frame(8'hA5, 1'b1, 1);
    repeat (4) @(negedge clk);
    check("single_data", 32'(data_o), 32'hA5);
    check("single_valid_cycles", 32'(valid_cycles), 32'd1);
    check("single_rise", 32'(rise_cyc), 32'(e0 + RISE_OFS));
    check("single_flags", 32'({frame_err_o, overrun_o, parity_err_o}), 32'h0);
    check("single_busy", 32'(busy_o), 32'h0);

    // Start-bit glitch of 2 cycles
    clr_mon();
    rx_i = 1'b0;
    repeat (2) @(negedge clk);
    rx_i = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy_cycles", 32'(busy_cycles), 32'd4);
    check("glitch_valid_cycles", 32'(valid_cycles), 32'd0);
    check("glitch_flags", 32'({frame_err_o, overrun_o, parity_err_o}), 32'h0);
    check("glitch_busy", 32'(busy_o), 32'h0);

    // Overrun: two back-to-back bytes, consumer stalled
    ready_i = 1'b0;
    clr_mon();
    send_frame(8'h3C, 1'b1, 1);
    check("ovr_first_valid", 32'(valid_o), 32'h1);
    check("ovr_first_overrun", 32'(overrun_o), 32'h0);
    send_frame(8'hC3, 1'b1, 1);
    repeat (4) @(negedge clk);
    check("ovr_data", 32'(data_o), 32'h3C);
    check("ovr_valid", 32'(valid_o), 32'h1);
    check("ovr_flag", 32'(overrun_o), 32'h1);
    check("ovr_frame_err", 32'(frame_err_o), 32'h0);
    ready_i = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", 32'(valid_o), 32'h0);
    check("ovr_data_hold", 32'(data_o), 32'h3C);
    check("ovr_flag_sticky", 32'(overrun_o), 32'h1);
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    check("ovr_clear", 32'(overrun_o), 32'h0);

    // Framing error: stop bit low, line held low three bit times
    clr_mon();
    send_frame(8'h55, 1'b0, 3);
    check("ferr_flag", 32'(frame_err_o), 32'h1);
    check("ferr_busy_low", 32'(busy_o), 32'h1);
    repeat (4) @(negedge clk);
    check("ferr_busy_release", 32'(busy_o), 32'h0);
    check("ferr_valid_cycles", 32'(valid_cycles), 32'd0);
    check("ferr_data_hold", 32'(data_o), 32'h3C);

    // Reset during data bit 4 of 0x81 (frame_err_o still set going in)
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre_busy", 32'(busy_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", 32'(data_o), 32'h00);
    check("rst_mid_valid", 32'(valid_o), 32'h0);
    check("rst_mid_busy", 32'(busy_o), 32'h0);
    check("rst_mid_flags", 32'({frame_err_o, overrun_o, parity_err_o}), 32'h0);
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clr_mon();
    e0 = cyc;
    send_frame(8'h81, 1'b1, 1);
    repeat (4) @(negedge clk);
    check("rst_next_data", 32'(data_o), 32'h81);
    check("rst_next_valid_cycles", 32'(valid_cycles), 32'd1);
    check("rst_next_rise", 32'(rise_cyc), 32'(e0 + RISE_OFS));
    check("rst_next_flags", 32'({frame_err_o, overrun_o, parity_err_o}), 32'h0);

`ifdef RETROSOC_UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1
    clr_mon();
    send_frame_par(8'h07, 1'b0);
    repeat (4) @(negedge clk);
    check("par_bad_flag", 32'(parity_err_o), 32'h1);
    check("par_bad_valid_cycles", 32'(valid_cycles), 32'd0);
    check("par_bad_frame_err", 32'(frame_err_o), 32'h0);
    clr_mon();
    send_frame_par(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    check("par_good_data", 32'(data_o), 32'h07);
    check("par_good_valid_cycles", 32'(valid_cycles), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, passed + fails);
    $finish;
  end

endmodule
